// File: rtl/adc_readout_arbiter_pkg.sv
// adc_readout_arbiter_pkg: shared state encoding and fixed pipe words for the ADC readout arbiter
package adc_readout_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, XFER = 2'd2} state_t;
    localparam logic [3:0] HDR_TAG = 4'hA;
    localparam logic [15:0] UNDERRUN_WORD = 16'hFFFF;
endpackage

// File: rtl/adc_readout_arbiter_rr_picker.sv
// adc_readout_arbiter_rr_picker: first set request bit searching ptr+1, ptr+2, ... mod N
module adc_readout_arbiter_rr_picker
    import adc_readout_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic         found,
    output logic [3:0]   idx
);
    always_comb begin
        found = 1'b0;
        idx = '0;
        // walk from farthest to nearest so the nearest hit is the one left standing
        for (int k = N; k >= 1; k--) begin
            if (((req >> ((int'(ptr) + k) % N)) & N'(1)) != '0) begin
                found = 1'b1;
                idx = 4'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/adc_readout_arbiter.sv
// adc_readout_arbiter: round-robin block readout of per-channel ADC FIFOs onto one pipe-out endpoint
module adc_readout_arbiter
    import adc_readout_arbiter_pkg::*;
#(
    parameter int NCH = 4,
    parameter int PRECISION = 10,
    parameter int CNT_W = 12,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NCH*CNT_W-1:0]     ch_count,
    input  logic [NCH*PRECISION-1:0] ch_dout,
    output logic [NCH-1:0]           ch_rd_en,
    input  logic                     pipe_read,
    output logic [15:0]              pipe_data,
    output logic                     block_ready,
    output logic [3:0]               grant_ch,
    output logic                     underrun,
    output logic [7:0]               blk_seq
);
    localparam logic [CNT_W-1:0] BW = CNT_W'(BLOCK_WORDS);
    state_t state, state_n;
    logic [3:0] rr_ptr, ptr_n, grant_n, pick;
    logic [CNT_W-1:0] idx, idx_n;
    logic [7:0] seq_n;
    logic [NCH-1:0] elig;
    logic found, hdr_q;
    logic [15:0] word_q, dout_sel;

    for (genvar i = 0; i < NCH; i++) begin : g_elig
        assign elig[i] = ch_count[i*CNT_W +: CNT_W] >= BW;
    end

    adc_readout_arbiter_rr_picker #(.N(NCH)) u_picker (
        .req(elig),
        .ptr(rr_ptr),
        .found(found),
        .idx(pick)
    );

    assign dout_sel = 16'(ch_dout[grant_ch*PRECISION +: PRECISION]);
    // FIFO dout is live only the cycle after a data read; otherwise the latched word is shown
    assign pipe_data = hdr_q ? word_q : dout_sel;
    assign block_ready = state != IDLE;

    always_comb begin
        state_n = state;
        ptr_n = rr_ptr;
        grant_n = grant_ch;
        idx_n = idx;
        seq_n = blk_seq;
        ch_rd_en = (rst_n && state == XFER && pipe_read) ? NCH'(1) << grant_ch : '0;
        case (state)
            IDLE: if (enable && found) begin
                state_n = READY;
                ptr_n = pick;
                grant_n = pick;
                idx_n = '0;
            end
            READY: if (pipe_read) begin
                state_n = XFER;
                idx_n = CNT_W'(1);
            end
            XFER: if (pipe_read) begin
                idx_n = idx + 1'b1;
                state_n = idx == BW ? IDLE : XFER;
                seq_n = idx == BW ? blk_seq + 1'b1 : blk_seq;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= 4'(NCH - 1);
            idx <= '0;
            grant_ch <= '0;
            blk_seq <= '0;
            underrun <= 1'b0;
            hdr_q <= 1'b1;
            word_q <= '0;
        end else begin
            state <= state_n;
            rr_ptr <= ptr_n;
            idx <= idx_n;
            grant_ch <= grant_n;
            blk_seq <= seq_n;
            underrun <= underrun | (state == IDLE && pipe_read);
            if (pipe_read) begin
                hdr_q <= state != XFER;
                word_q <= state == READY ? {HDR_TAG, grant_ch, blk_seq} :
                          state == IDLE ? UNDERRUN_WORD : word_q;
            end else if (!hdr_q) begin
                hdr_q <= 1'b1;
                word_q <= dout_sel;
            end
        end
    end
endmodule

// File: doc/adc_readout_arbiter.md
Name: adc_readout_arbiter

Overview:
- Shares the single host pipe-out endpoint between NCH per-channel ADC sample FIFOs, e.g. chip ADC_0..ADC_3.
- Round-robin grants one channel at a time once that channel holds a full block of BLOCK_WORDS samples.
- Each block goes out as one header word followed by BLOCK_WORDS zero-extended samples.
- Sits between the channel FIFO read ports and the pipe-out endpoint; block_ready drives a wire-out status bit that the host polls.

Parameters:
- NCH, 4, number of channel FIFOs (1..16).
- PRECISION, 10, ADC code width (<=16).
- CNT_W, 12, FIFO read-count width.
- BLOCK_WORDS, 256, samples per block (1..2^CNT_W-1).

Ports:
- clk  in  1  single clock, pipe/FIFO read clock domain.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  allow new grants; from wire-in.
- ch_count  in  NCH*CNT_W  per-channel FIFO read-side word count; channel i at [i*CNT_W +: CNT_W].
- ch_dout  in  NCH*PRECISION  per-channel FIFO dout. Standard FIFO: valid the cycle after rd_en.
- ch_rd_en  out  NCH  per-channel FIFO read enable.
- pipe_read  in  1  host read strobe from the pipe-out endpoint.
- pipe_data  out  16  word to the endpoint; valid the cycle after pipe_read.
- block_ready  out  1  a block is granted and waiting or in transfer.
- grant_ch  out  4  currently or last granted channel.
- underrun  out  1  sticky: pipe_read seen while IDLE.
- blk_seq  out  8  count of completed blocks, wraps at 255.

Behaviour:
- Reset (rst_n=0 at posedge clk) forces the following:
  - state=IDLE, rr_ptr=NCH-1 (so channel 0 is searched first), idx=0.
  - ch_rd_en=0, pipe_data=16'h0000, block_ready=0, grant_ch=0, underrun=0, blk_seq=0.
  - Reset mid-transfer abandons the block with no further FIFO reads; the host must also reset the FIFOs.
- States: IDLE, READY, XFER.
- IDLE:
  - If enable=1 and some channel has ch_count >= BLOCK_WORDS, grant the first such channel searching rr_ptr+1, rr_ptr+2, ... mod NCH.
  - Set grant_ch, rr_ptr=granted channel, idx=0, go to READY. Grant takes 1 cycle.
  - Multiple eligible channels: strict round-robin order. A channel just served is lowest priority next time.
- READY:
  - block_ready=1.
  - On pipe_read: next cycle pipe_data = header {4'hA, grant_ch[3:0], blk_seq[7:0]}; idx=1; go to XFER. No FIFO read.
- XFER:
  - block_ready=1.
  - On pipe_read: ch_rd_en[grant_ch]=pipe_read, combinational in the same cycle.
  - Next cycle pipe_data = {(16-PRECISION)'b0, ch_dout[grant_ch]}; idx increments.
  - The read with idx==BLOCK_WORDS is the last: next state IDLE, blk_seq+1 (wraps 255->0).
  - Once the last read has been accepted, block_ready is 0 in the following cycle.
- pipe_data select:
  - Registered flag hdr_q (1 = header, 0 = FIFO data) chooses the header or the granted channel's dout.
  - pipe_data holds its last value when no pipe_read occurred in the previous cycle.
- pipe_read in IDLE: underrun=1 (sticky until reset), no FIFO read, pipe_data=16'hFFFF next cycle.
- enable=0 mid-block: the current block completes normally; no new grant until enable=1.
- Word count: exactly BLOCK_WORDS+1 pipe words per block.
- FIFO empty is impossible during a granted block, because ch_count >= BLOCK_WORDS was checked at grant and the FIFOs are only drained here. No empty check is required; verification asserts it.
- At most one ch_rd_en bit is high in any cycle, and only in XFER coincident with pipe_read.
- Back-to-back pipe_read in every cycle is supported; there are no bubbles between words.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, READY=2'd1, XFER=2'd2), HDR_TAG=4'hA, UNDERRUN_WORD=16'hFFFF.
- One natural sub-module: rr_picker, combinational round-robin first-eligible search over NCH request bits from rr_ptr+1. It returns a found flag and an index.

Test Plan:
- Single block: NCH=4, BLOCK_WORDS=4; ch1 count=4 holding 10,11,12,13.
  - 5 pipe_reads give 0xA100, 0x000A, 0x000B, 0x000C, 0x000D.
  - ch_rd_en=4'b0010 on reads 2-5 only; blk_seq=1; block_ready falls after the 5th read.
- Round robin: all four channels with count >= BLOCK_WORDS, repeated blocks -> grant order 0,1,2,3,0. Headers carry seq 0..4.
- Underrun: pipe_read with all counts 0 -> pipe_data=0xFFFF, underrun=1 and stays high; no ch_rd_en.
- enable dropped after the header of a ch2 block -> remaining 4 data words still delivered; no new grant while enable=0 even with ch3 eligible. Raising enable grants ch3.
- Reset mid-XFER, after 2 data words: rst_n=0 for 1 cycle -> all outputs return to their reset values and ch_rd_en=0. The next grant starts at ch0 with seq 0.
- blk_seq wrap: complete 256 blocks -> the header of the 257th block carries seq 0x00.
